restador_serial: RTL and testbench
==================================

Name: restador_serial

Overview:
Multi-cycle bit-serial subtractor, the inverse counterpart of the team's parallel N-bit adder with NZCV flags. It computes Diff = A - B - Bin one bit per clock, LSB first, behind a start/done handshake, and produces the same NZCV flag set. It is used in area-constrained datapaths where a full-width subtractor is not affordable.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend, sampled when start is accepted
b  input  WIDTH  subtrahend, sampled when start is accepted
bin  input  1  borrow-in, sampled when start is accepted
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result and flags valid
diff  output  WIDTH  difference, held until the next accepted start completes
flag_n  output  1  negative: diff[WIDTH-1]
flag_z  output  1  zero: diff == 0
flag_c  output  1  carry = NOT final borrow (1 when a >= b + bin, unsigned)
flag_v  output  1  signed overflow: (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB])

Behaviour:
- Reset: clk edge with rst_n=0 forces the state to IDLE. busy, done, diff, and all flags go to 0. Counter, shift registers, and the borrow register clear. This applies in every state, including mid-RUN; the partial result is discarded and done is not issued.
- FSM states are IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, load a_sh<=a, b_sh<=b, borrow<=bin, save a[MSB] and b[MSB], cnt<=0, then go to RUN. Otherwise stay in IDLE.
- RUN: busy=1. Each edge computes d = a_sh[0]^b_sh[0]^borrow and bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow). It shifts a_sh and b_sh right, shifts d into the result register MSB, updates borrow<=bo, and increments cnt.
- RUN exit: on the edge where cnt == WIDTH-1, go to DONE. On that same edge, diff and all flags update from the completed result and the final borrow.
- RUN ignores start.
- DONE: lasts exactly one cycle. done=1, busy=0.
  - start=1 at that edge: accepted exactly as in IDLE, so back-to-back operations are legal; go to RUN.
  - start=0 at that edge: go to IDLE.
- Latency: start is accepted at edge k. done is high during the cycle following edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- diff and flags change only on the RUN-exit edge or on reset, never during RUN.
- Widths: no internal width extension. The borrow chain is 1 bit. cnt is $clog2(WIDTH) bits, and counts up to WIDTH-1 with no wrap beyond that.
- Operands change after acceptance: no effect on the operation in flight.
- Bin semantics: bin=1 subtracts an extra 1. This matches chaining, where the upstream flag_c inverted feeds bin.

Decomposition:
- Shared package restador_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} rs_state_t
  - the flag bundle typedef struct packed {n, z, c, v} nzcv_t, reused by the adder.
- One sub-module, restador_bit: a combinational 1-bit full subtractor (a, b, bin -> d, bout), instantiated once in the serial datapath.

Test Plan:
- WIDTH=4, a=5, b=3, bin=0, start one cycle -> busy high 4 cycles; done at cycle 5; diff=2, N0 Z0 C1 V0.
- a=3, b=5, bin=0 -> diff=14 (4'b1110), N1 Z0 C0 V0.
- a=7, b=15 (-1), bin=0 -> diff=8 (4'b1000), N1 Z0 C0 V1. Also a=4, b=4 -> diff=0, Z1 C1 N0 V0.
- a=0, b=0, bin=1 -> diff=15, N1 Z0 C0 V0.
- Start pulsed again during RUN with a=9 -> ignored; the first result completes unchanged. Start held high in DONE -> new op accepted; done pulses every 5 cycles.
- Sequence:
  - Complete op a=5, b=3 -> diff=2.
  - Start a=6, b=1.
  - Drive rst_n=0 at the 2nd RUN cycle -> next edge: IDLE, busy=0, diff=0, flags=0, no done.
  - Release reset, restart a=6, b=1 -> diff=5, C1.

Source files
------------

// File: rtl/restador_pkg.sv
//------------------------------------------------------------------------------
// Module   : restador_pkg
// Purpose  : Shared state and NZCV flag types for the serial subtractor and
//            the parallel adder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package restador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rs_state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    localparam nzcv_t c_NZCV_CLEAR = '0;

endpackage

`default_nettype wire

// File: rtl/restador_bit.sv
//------------------------------------------------------------------------------
// Module   : restador_bit
// Purpose  : Combinational 1-bit full subtractor (a - b - bin).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module restador_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

`default_nettype wire

// File: rtl/restador_serial.sv
//------------------------------------------------------------------------------
// Module   : restador_serial
// Purpose  : Bit-serial subtractor, diff = a - b - bin, LSB first, with a
//            start/done handshake and NZCV flags.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module restador_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    import restador_pkg::*;

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    rs_state_t          r_state;
    rs_state_t          w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic [WIDTH-1:0]   w_res_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_borrow;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               w_d;
    logic               w_bout;
    logic               w_accept;
    logic               w_last;
    nzcv_t              r_flags;
    nzcv_t              w_flags_final;

    restador_bit u_bit (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_cnt == c_CNT_LAST);

    // New bit enters at the MSB; after WIDTH shifts the LSB of the result sits at bit 0.
    assign w_res_next = {w_d, {(WIDTH-1){1'b0}}} | (r_res >> 1);

    assign w_flags_final.n = w_res_next[WIDTH-1];
    assign w_flags_final.z = (w_res_next == '0);
    assign w_flags_final.c = ~w_bout;
    assign w_flags_final.v = (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_res_next[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_flags  <= c_NZCV_CLEAR;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_res    <= '0;
            r_borrow <= bin;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res    <= w_res_next;
            r_borrow <= w_bout;
            if (w_last) begin
                r_diff  <= w_res_next;
                r_flags <= w_flags_final;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign diff   = r_diff;
    assign flag_n = r_flags.n;
    assign flag_z = r_flags.z;
    assign flag_c = r_flags.c;
    assign flag_v = r_flags.v;

endmodule

`default_nettype wire

// File: tb/tb_restador_serial.sv
//------------------------------------------------------------------------------
// Module   : tb_restador_serial
// Purpose  : Self-checking bench for restador_serial against an arithmetic
//            reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_restador_serial;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    int checks   = 0;
    int failures = 0;

    // Currently published result as the model sees it
    int exp_diff  = 0;
    int exp_flags = 0;

    restador_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= (1 << (W-1))) ? v - (1 << W) : v;
    endfunction

    // Reference: plain integer arithmetic, flags packed as {n,z,c,v}
    task automatic model(input int ta, input int tb, input int tbin,
                         output int md, output int mf);
        int full, sres, n, z, c, v;
        full = ta - tb - tbin;
        md   = full & MASK;
        c    = (ta >= tb + tbin) ? 1 : 0;
        sres = to_signed(ta) - to_signed(tb) - tbin;
        v    = (sres < -(1 << (W-1)) || sres > (1 << (W-1)) - 1) ? 1 : 0;
        n    = (md >> (W-1)) & 1;
        z    = (md == 0) ? 1 : 0;
        mf   = (n << 3) | (z << 2) | (c << 1) | v;
    endtask

    function automatic logic [31:0] flags_obs();
        return {28'd0, flag_n, flag_z, flag_c, flag_v};
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE; returns at the done negedge.
    task automatic run_op(input int ta, input int tb, input int tbin, input bit noise);
        int md, mf;
        model(ta, tb, tbin, md, mf);
        start = 1'b1;
        a     = W'(ta);
        b     = W'(tb);
        bin   = tbin[0];
        for (int n = 1; n <= W; n++) begin
            @(negedge clk);
            start = 1'b0;
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_diff_held", 32'(diff), 32'(exp_diff));
            check("run_flags_held", flags_obs(), 32'(exp_flags));
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        start     = 1'b0;
        exp_diff  = md;
        exp_flags = mf;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check($sformatf("diff_%0d_%0d_%0d", ta, tb, tbin), 32'(diff), 32'(md));
        check($sformatf("nzcv_%0d_%0d_%0d", ta, tb, tbin), flags_obs(), 32'(mf));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_diff", 32'(diff), 32'(exp_diff));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_flags", flags_obs(), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // Directed corner cases
        run_op(5, 3, 0, 1'b0);
        idle_cycle();
        run_op(3, 5, 0, 1'b0);
        run_op(7, 15, 0, 1'b0);
        run_op(4, 4, 0, 1'b0);
        idle_cycle();
        run_op(0, 0, 1, 1'b0);
        idle_cycle();

        // Start re-pulsed during RUN with a=9: must not disturb the op in flight
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd3;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (W - 2) @(negedge clk);
        check("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        exp_diff  = 2;
        exp_flags = 4'b0010;
        check("ign_done", 32'(done), 32'd1);
        check("ign_diff", 32'(diff), 32'd2);
        check("ign_flags", flags_obs(), 32'(exp_flags));
        idle_cycle();
        idle_cycle();

        // Reset in the middle of RUN discards the operation
        run_op(5, 3, 0, 1'b0);
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd1;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_diff  = 0;
        exp_flags = 0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_flags", flags_obs(), 32'd0);
        repeat (W + 2) idle_cycle();
        run_op(6, 1, 0, 1'b0);
        idle_cycle();

        // Randomized back-to-back and gapped operations with input noise
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
                   int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) idle_cycle();
            end
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
